id_pipeline: RTL

//  RV32I decode stage: consumes IF/ID outputs (inst, pc, pc+4), reads 32x32 register file, generates immediate + control.

---
 rtl/id_pipeline_pkg.sv | 79 +++++++
 rtl/reg_file_32x32.sv | 42 ++++
 rtl/id_pipeline.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/id_pipeline_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/writeback codes, ID/EX record and immediate helper.
package id_pipeline_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU op is {funct7[5], funct3} for register/immediate arithmetic
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_COPY_B = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // One ID/EX entry; an all-zero value is a bubble
    typedef struct packed {
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            reg_wen;
        logic            mem_rw;
        logic            mem_read;
        logic            a_sel;
        logic            b_sel;
        logic            br_un;
        logic            branch;
        logic            jump;
        logic [3:0]      alu_sel;
        logic [1:0]      wb_sel;
    } idex_t;

    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two async read ports, one sync write port, write-first bypass, x0 tied to zero.
module reg_file_32x32
    import id_pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != 5'd0);

    // Clear every register on reset, otherwise commit the writeback (x0 never written)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads see a same-cycle write to the same register; x0 always reads zero
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (wr_live && (wr_addr == rs1_addr)) rs1_data = wr_data;
        if (wr_live && (wr_addr == rs2_addr)) rs2_data = wr_data;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

endmodule

// File: rtl/id_pipeline.sv
// RV32I decode stage: register read, immediate/control decode, load-use hazard and ID/EX register.
module id_pipeline
    import id_pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pcPlus4_in,
    input  logic            flush_in,
    input  logic            wb_we_in,
    input  logic [4:0]      wb_rd_in,
    input  logic [XLEN-1:0] wb_data_in,
    output logic            stall_out,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pcPlus4_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      funct3_out,
    output logic            regWEn_out,
    output logic            memRW_out,
    output logic            memRead_out,
    output logic            aSel_out,
    output logic            bSel_out,
    output logic            brUn_out,
    output logic            branch_out,
    output logic            jump_out,
    output logic [3:0]      aluSel_out,
    output logic [1:0]      wbSel_out
);

    logic [6:0]      opcode;
    logic [4:0]      rs1_field;
    logic [4:0]      rs2_field;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic            rs1_used;
    logic            rs2_used;
    logic            valid;
    logic            load_use;
    imm_fmt_e        fmt;
    idex_t           dec;
    idex_t           idex;

    assign opcode    = inst_in[6:0];
    assign rs1_field = inst_in[19:15];
    assign rs2_field = inst_in[24:20];

    // Unused source operands read x0 so their data fields come out as zero
    assign rs1_idx = rs1_used ? rs1_field : 5'd0;
    assign rs2_idx = rs2_used ? rs2_field : 5'd0;

    reg_file_32x32 u_reg_file (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs1_addr (rs1_idx),
        .rs2_addr (rs2_idx),
        .rs1_data (rs1_rdata),
        .rs2_data (rs2_rdata),
        .wr_en    (wb_we_in),
        .wr_addr  (wb_rd_in),
        .wr_data  (wb_data_in)
    );

    // Decode the incoming instruction into a full ID/EX record; unknown opcodes become a bubble
    always_comb begin
        dec      = '0;
        valid    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        fmt      = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                dec.reg_wen = 1'b1; dec.b_sel = 1'b1; dec.alu_sel = ALU_COPY_B; fmt = IMM_U;
            end
            OPC_AUIPC: begin
                dec.reg_wen = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1; fmt = IMM_U;
            end
            OPC_JAL: begin
                dec.reg_wen = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1; dec.jump = 1'b1;
                dec.wb_sel = WB_PC4; fmt = IMM_J;
            end
            OPC_JALR: begin
                dec.reg_wen = 1'b1; dec.b_sel = 1'b1; dec.jump = 1'b1;
                dec.wb_sel = WB_PC4; fmt = IMM_I; rs1_used = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1; dec.a_sel = 1'b1; dec.br_un = inst_in[13];
                fmt = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                dec.reg_wen = 1'b1; dec.mem_read = 1'b1; dec.b_sel = 1'b1;
                dec.wb_sel = WB_MEM; fmt = IMM_I; rs1_used = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_rw = 1'b1; dec.b_sel = 1'b1; fmt = IMM_S;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_OPIMM: begin
                dec.reg_wen = 1'b1; dec.b_sel = 1'b1; fmt = IMM_I; rs1_used = 1'b1;
                dec.alu_sel = {(inst_in[14:12] == 3'b101) ? inst_in[30] : 1'b0, inst_in[14:12]};
            end
            OPC_OP: begin
                dec.reg_wen = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
                dec.alu_sel = {inst_in[30], inst_in[14:12]};
            end
            default: valid = 1'b0;
        endcase
        if (valid) begin
            dec.imm      = imm_gen(inst_in, fmt);
            dec.pc       = pc_in;
            dec.pc_plus4 = pcPlus4_in;
            dec.rs1      = rs1_idx;
            dec.rs2      = rs2_idx;
            dec.rs1_data = rs1_rdata;
            dec.rs2_data = rs2_rdata;
            dec.rd       = dec.reg_wen ? inst_in[11:7] : 5'd0;
            dec.funct3   = rs1_used ? inst_in[14:12] : 3'd0;
        end
    end

    // Load-use hazard against the load sitting in ID/EX; a redirect squashes it instead
    always_comb begin
        load_use  = idex.mem_read && (idex.rd != 5'd0) &&
                    ((rs1_used && (idex.rd == rs1_field)) || (rs2_used && (idex.rd == rs2_field)));
        stall_out = load_use && !flush_in;
    end

    // ID/EX register: reset and flush/stall all load a bubble
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idex <= '0;
        end else if (flush_in || load_use) begin
            idex <= '0;
        end else begin
            idex <= dec;
        end
    end

    assign rs1_data_out = idex.rs1_data;
    assign rs2_data_out = idex.rs2_data;
    assign imm_out      = idex.imm;
    assign pc_out       = idex.pc;
    assign pcPlus4_out  = idex.pc_plus4;
    assign rs1_out      = idex.rs1;
    assign rs2_out      = idex.rs2;
    assign rd_out       = idex.rd;
    assign funct3_out   = idex.funct3;
    assign regWEn_out   = idex.reg_wen;
    assign memRW_out    = idex.mem_rw;
    assign memRead_out  = idex.mem_read;
    assign aSel_out     = idex.a_sel;
    assign bSel_out     = idex.b_sel;
    assign brUn_out     = idex.br_un;
    assign branch_out   = idex.branch;
    assign jump_out     = idex.jump;
    assign aluSel_out   = idex.alu_sel;
    assign wbSel_out    = idex.wb_sel;

endmodule
